// File: rtl/jtag_dbg_pkg.sv
// Shared defaults, helpers and the default-width command entry for the JTAG debug command bridge.
package jtag_dbg_pkg;

    localparam int unsigned DEF_IR_WIDTH = 2;
    localparam int unsigned DEF_DR_WIDTH = 38;
    localparam int unsigned DEF_ACT_BIT  = 34;

    // Ceiling log2, usable in constant expressions for port and pointer widths.
    function automatic int unsigned clog2(input int unsigned n);
        int unsigned r;
        r = 0;
        while ((64'd1 << r) < 64'(n)) begin
            r = r + 1;
        end
        return r;
    endfunction

    typedef struct packed {
        logic [DEF_IR_WIDTH-1:0] ir;
        logic [DEF_DR_WIDTH-1:0] data;
    } cmd_entry_t;

endpackage

// File: rtl/jtag_dbg_sync.sv
// Multi-flop level synchroniser followed by a rising-edge detector.
module jtag_dbg_sync #(
    parameter int unsigned STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic level_i,
    output logic rise_c
);

    logic [STAGES-1:0] sync_q;
    logic              hist_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q <= '0;
            hist_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], level_i};
            hist_q <= sync_q[STAGES-1];
        end
    end

    // One-cycle pulse per synchronised rising edge; a held level does not repeat.
    assign rise_c = sync_q[STAGES-1] & ~hist_q;

endmodule

// File: rtl/jtag_debug_cmd_bridge.sv
// System-clock side of the CPU JTAG debug module: synchronises update strobes,
// queues {ir, data} commands and emits one-hot action strobes on pop.
module jtag_debug_cmd_bridge
    import jtag_dbg_pkg::*;
#(
    parameter int unsigned IR_WIDTH    = DEF_IR_WIDTH,
    parameter int unsigned DR_WIDTH    = DEF_DR_WIDTH,
    parameter int unsigned ACT_BIT     = DEF_ACT_BIT,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned QDEPTH      = 4
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      vs_uir,
    input  logic                      vs_udr,
    input  logic [IR_WIDTH-1:0]       ir_in,
    input  logic [DR_WIDTH-1:0]       sr,
    input  logic                      cmd_ready,
    input  logic                      ovf_clr,
    output logic                      cmd_valid,
    output logic [IR_WIDTH-1:0]       cmd_ir,
    output logic [DR_WIDTH-1:0]       jdo,
    output logic                      cmd_action,
    output logic [(2**IR_WIDTH)-1:0]  take_action,
    output logic [(2**IR_WIDTH)-1:0]  take_no_action,
    output logic                      overflow,
    output logic [clog2(QDEPTH):0]    q_level
);

    localparam int unsigned AW  = clog2(QDEPTH);
    localparam int unsigned PW  = AW + 1;
    localparam int unsigned NCH = 2 ** IR_WIDTH;

    typedef struct packed {
        logic [IR_WIDTH-1:0] ir;
        logic [DR_WIDTH-1:0] data;
    } entry_t;

    logic uir_rise;
    logic udr_rise;

    jtag_dbg_sync #(.STAGES(SYNC_STAGES)) u_sync_uir (
        .clk     (clk),
        .reset   (reset),
        .level_i (vs_uir),
        .rise_c  (uir_rise)
    );

    jtag_dbg_sync #(.STAGES(SYNC_STAGES)) u_sync_udr (
        .clk     (clk),
        .reset   (reset),
        .level_i (vs_udr),
        .rise_c  (udr_rise)
    );

    entry_t              mem_q [QDEPTH];
    logic [IR_WIDTH-1:0] ir_q, ir_d;
    logic [PW-1:0]       wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]       rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]       level_q, level_d;
    logic                ovf_q, ovf_d;
    logic                cmd_valid_q, cmd_valid_d;
    logic [IR_WIDTH-1:0] cmd_ir_q, cmd_ir_d;
    logic [DR_WIDTH-1:0] jdo_q, jdo_d;
    logic                cmd_action_q, cmd_action_d;
    logic [NCH-1:0]      act_q, act_d;
    logic [NCH-1:0]      nact_q, nact_d;
    logic                full;
    logic                pop;
    logic                push;
    logic                drop;
    entry_t              push_entry;
    entry_t              head;

    always_comb begin
        ir_d         = ir_q;
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        ovf_d        = ovf_q;
        cmd_ir_d     = cmd_ir_q;
        jdo_d        = jdo_q;
        cmd_action_d = cmd_action_q;
        act_d        = '0;
        nact_d       = '0;

        // A coincident uir edge must feed the freshly captured instruction into the push.
        if (uir_rise) begin
            ir_d = ir_in;
        end
        push_entry = '{ir: ir_d, data: sr};

        full = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
        pop  = cmd_valid_q & cmd_ready;
        push = udr_rise & (~full | pop);
        drop = udr_rise & full & ~pop;

        if (push) begin
            wr_ptr_d = wr_ptr_q + PW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        level_d = wr_ptr_d - rd_ptr_d;

        if (drop) begin
            ovf_d = 1'b1;
        end else if (ovf_clr) begin
            ovf_d = 1'b0;
        end

        // Head registers only see committed entries, so a push shows up one cycle after it lands.
        head        = mem_q[rd_ptr_d[AW-1:0]];
        cmd_valid_d = (rd_ptr_d != wr_ptr_q);
        if (cmd_valid_d) begin
            cmd_ir_d     = head.ir;
            jdo_d        = head.data;
            cmd_action_d = head.data[ACT_BIT];
        end

        if (pop) begin
            if (cmd_action_q) begin
                act_d[cmd_ir_q] = 1'b1;
            end else begin
                nact_d[cmd_ir_q] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ir_q         <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            level_q      <= '0;
            ovf_q        <= 1'b0;
            cmd_valid_q  <= 1'b0;
            cmd_ir_q     <= '0;
            jdo_q        <= '0;
            cmd_action_q <= 1'b0;
            act_q        <= '0;
            nact_q       <= '0;
        end else begin
            ir_q         <= ir_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            level_q      <= level_d;
            ovf_q        <= ovf_d;
            cmd_valid_q  <= cmd_valid_d;
            cmd_ir_q     <= cmd_ir_d;
            jdo_q        <= jdo_d;
            cmd_action_q <= cmd_action_d;
            act_q        <= act_d;
            nact_q       <= nact_d;
        end
    end

    // Storage needs no reset: entries are only read once the pointers say they were written.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= push_entry;
        end
    end

    assign cmd_valid      = cmd_valid_q;
    assign cmd_ir         = cmd_ir_q;
    assign jdo            = jdo_q;
    assign cmd_action     = cmd_action_q;
    assign take_action    = act_q;
    assign take_no_action = nact_q;
    assign overflow       = ovf_q;
    assign q_level        = level_q;

endmodule

// File: tb/tb_jtag_debug_cmd_bridge.sv
// Scoreboard bench for jtag_debug_cmd_bridge: expected commands are queued when
// update-DR is driven and checked at each pop, with strobes checked the following cycle.
module tb_jtag_debug_cmd_bridge;

    localparam int unsigned IRW = 2;
    localparam int unsigned DRW = 38;
    localparam int unsigned ACT = 34;

    logic             clk;
    logic             reset;
    logic             vs_uir;
    logic             vs_udr;
    logic [IRW-1:0]   ir_in;
    logic [DRW-1:0]   sr;
    logic             cmd_ready;
    logic             ovf_clr;
    logic             cmd_valid;
    logic [IRW-1:0]   cmd_ir;
    logic [DRW-1:0]   jdo;
    logic             cmd_action;
    logic [3:0]       take_action;
    logic [3:0]       take_no_action;
    logic             overflow;
    logic [2:0]       q_level;

    typedef struct {
        logic [IRW-1:0] ir;
        logic [DRW-1:0] data;
    } exp_t;

    exp_t       sb[$];
    int         n_cmp;
    int         n_bad;
    int         strobe_cnt;
    logic [3:0] exp_act;
    logic [3:0] exp_nact;

    jtag_debug_cmd_bridge dut (
        .clk            (clk),
        .reset          (reset),
        .vs_uir         (vs_uir),
        .vs_udr         (vs_udr),
        .ir_in          (ir_in),
        .sr             (sr),
        .cmd_ready      (cmd_ready),
        .ovf_clr        (ovf_clr),
        .cmd_valid      (cmd_valid),
        .cmd_ir         (cmd_ir),
        .jdo            (jdo),
        .cmd_action     (cmd_action),
        .take_action    (take_action),
        .take_no_action (take_no_action),
        .overflow       (overflow),
        .q_level        (q_level)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Pop checker and strobe checker: a pop seen now must produce exactly one strobe bit next cycle.
    always @(negedge clk) begin
        exp_t e;
        if (reset) begin
            exp_act  = '0;
            exp_nact = '0;
        end else begin
            n_cmp++;
            if (take_action !== exp_act || take_no_action !== exp_nact) begin
                n_bad++;
                $display("FAIL strobe: act=%b nact=%b expected act=%b nact=%b",
                         take_action, take_no_action, exp_act, exp_nact);
            end
            if (take_action != 4'b0 || take_no_action != 4'b0) strobe_cnt++;
            exp_act  = '0;
            exp_nact = '0;
            if (cmd_valid && cmd_ready) begin
                n_cmp++;
                if (sb.size() == 0) begin
                    n_bad++;
                    $display("FAIL unexpected_pop: jdo=%h with empty scoreboard", jdo);
                end else begin
                    e = sb.pop_front();
                    if ({cmd_ir, jdo, cmd_action} !== {e.ir, e.data, e.data[ACT]}) begin
                        n_bad++;
                        $display("FAIL pop_data: ir=%b jdo=%h act=%b expected ir=%b jdo=%h act=%b",
                                 cmd_ir, jdo, cmd_action, e.ir, e.data, e.data[ACT]);
                    end
                    if (e.data[ACT]) exp_act[e.ir] = 1'b1;
                    else             exp_nact[e.ir] = 1'b1;
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic uir_update(input logic [IRW-1:0] ir);
        ir_in  = ir;
        vs_uir = 1'b1;
        tick(3);
        vs_uir = 1'b0;
        tick(3);
    endtask

    // Leaves the bench just after edge 2; the push lands on the next edge.
    task automatic udr_rise(input logic [DRW-1:0] d);
        sr     = d;
        vs_udr = 1'b1;
        tick(2);
    endtask

    task automatic udr_finish();
        tick(1);
        vs_udr = 1'b0;
        tick(3);
    endtask

    task automatic push_exp(input logic [IRW-1:0] ir, input logic [DRW-1:0] d);
        exp_t e;
        e.ir   = ir;
        e.data = d;
        sb.push_back(e);
    endtask

    task automatic drain(input string name);
        for (int i = 0; i < 60 && sb.size() != 0; i++) tick(1);
        tick(3);
        n_cmp++;
        if (sb.size() != 0 || q_level !== 3'd0) begin
            n_bad++;
            $display("FAIL %s_drain: left=%0d q_level=%0d expected 0/0", name, sb.size(), q_level);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; vs_uir = 1'b0; vs_udr = 1'b0; ir_in = '0; sr = '0;
        cmd_ready = 1'b0; ovf_clr = 1'b0;
        tick(3);
        n_cmp++;
        if (cmd_valid !== 1'b0 || q_level !== 3'd0 || overflow !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_ctrl: valid=%b level=%0d ovf=%b expected 0", cmd_valid, q_level, overflow);
        end
        n_cmp++;
        if (jdo !== '0 || cmd_ir !== '0 || cmd_action !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_head: jdo=%h ir=%b act=%b expected 0", jdo, cmd_ir, cmd_action);
        end
        n_cmp++;
        if (take_action !== 4'b0 || take_no_action !== 4'b0) begin
            n_bad++;
            $display("FAIL reset_strobe: act=%b nact=%b expected 0", take_action, take_no_action);
        end
        reset = 1'b0;
        tick(2);
    endtask

    task automatic test_basic();
        int lat;
        int s0;
        cmd_ready = 1'b1;
        uir_update(2'b01);
        s0  = strobe_cnt;
        lat = 0;
        push_exp(2'b01, 38'h04_0000_1234);
        sr     = 38'h04_0000_1234;
        vs_udr = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            tick(1);
            if (cmd_valid) begin
                lat = i;
                break;
            end
        end
        n_cmp++;
        if (lat != 4) begin
            n_bad++;
            $display("FAIL basic_latency: cmd_valid after %0d clks expected 4", lat);
        end
        vs_udr = 1'b0;
        tick(6);
        n_cmp++;
        if (strobe_cnt != s0 + 1 || sb.size() != 0) begin
            n_bad++;
            $display("FAIL basic_strobe_count: strobes=%0d left=%0d expected 1/0", strobe_cnt - s0, sb.size());
        end
    endtask

    task automatic test_no_action();
        int s0;
        cmd_ready = 1'b1;
        uir_update(2'b11);
        s0 = strobe_cnt;
        push_exp(2'b11, 38'h00_0000_00AB);
        udr_rise(38'h00_0000_00AB);
        udr_finish();
        tick(4);
        n_cmp++;
        if (strobe_cnt != s0 + 1 || sb.size() != 0) begin
            n_bad++;
            $display("FAIL noact_strobe_count: strobes=%0d left=%0d expected 1/0", strobe_cnt - s0, sb.size());
        end
    endtask

    task automatic test_overflow();
        cmd_ready = 1'b0;
        uir_update(2'b00);
        for (int d = 1; d <= 4; d++) begin
            push_exp(2'b00, DRW'(d));
            udr_rise(DRW'(d));
            udr_finish();
        end
        n_cmp++;
        if (q_level !== 3'd4 || overflow !== 1'b0 || cmd_valid !== 1'b1) begin
            n_bad++;
            $display("FAIL ovf_fill: level=%0d ovf=%b valid=%b expected 4/0/1", q_level, overflow, cmd_valid);
        end
        // Fifth update drops; ovf_clr on the same edge must lose to the set.
        udr_rise(DRW'(5));
        ovf_clr = 1'b1;
        tick(1);
        ovf_clr = 1'b0;
        vs_udr  = 1'b0;
        tick(3);
        n_cmp++;
        if (overflow !== 1'b1 || q_level !== 3'd4) begin
            n_bad++;
            $display("FAIL ovf_drop: ovf=%b level=%0d expected 1/4", overflow, q_level);
        end
        ovf_clr = 1'b1;
        tick(1);
        ovf_clr = 1'b0;
        tick(1);
        n_cmp++;
        if (overflow !== 1'b0) begin
            n_bad++;
            $display("FAIL ovf_clear: ovf=%b expected 0", overflow);
        end
    endtask

    task automatic test_full_push_pop();
        push_exp(2'b00, DRW'(6));
        udr_rise(DRW'(6));
        cmd_ready = 1'b1;
        tick(1);
        cmd_ready = 1'b0;
        vs_udr    = 1'b0;
        tick(3);
        n_cmp++;
        if (q_level !== 3'd4 || overflow !== 1'b0) begin
            n_bad++;
            $display("FAIL full_pushpop: level=%0d ovf=%b expected 4/0", q_level, overflow);
        end
        cmd_ready = 1'b1;
        drain("full_pushpop");
    endtask

    task automatic test_coincident();
        int s0;
        cmd_ready = 1'b1;
        s0 = strobe_cnt;
        push_exp(2'b10, 38'h04_0000_00C3);
        ir_in  = 2'b10;
        sr     = 38'h04_0000_00C3;
        vs_uir = 1'b1;
        vs_udr = 1'b1;
        tick(3);
        vs_uir = 1'b0;
        vs_udr = 1'b0;
        tick(5);
        n_cmp++;
        if (strobe_cnt != s0 + 1 || sb.size() != 0) begin
            n_bad++;
            $display("FAIL coincident_count: strobes=%0d left=%0d expected 1/0", strobe_cnt - s0, sb.size());
        end
    endtask

    task automatic test_reset_mid();
        int s0;
        cmd_ready = 1'b0;
        for (int d = 1; d <= 5; d++) begin
            udr_rise(DRW'(d + 16));
            udr_finish();
        end
        n_cmp++;
        if (q_level !== 3'd4 || overflow !== 1'b1) begin
            n_bad++;
            $display("FAIL rstmid_pre: level=%0d ovf=%b expected 4/1", q_level, overflow);
        end
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        n_cmp++;
        if (cmd_valid !== 1'b0 || q_level !== 3'd0 || overflow !== 1'b0) begin
            n_bad++;
            $display("FAIL rstmid_post: valid=%b level=%0d ovf=%b expected 0/0/0", cmd_valid, q_level, overflow);
        end
        cmd_ready = 1'b1;
        s0 = strobe_cnt;
        tick(10);
        n_cmp++;
        if (strobe_cnt != s0) begin
            n_bad++;
            $display("FAIL rstmid_quiet: strobes=%0d expected 0", strobe_cnt - s0);
        end
        // Instruction register was cleared, so an update-DR alone must carry ir 0.
        push_exp(2'b00, 38'h04_0000_0077);
        udr_rise(38'h04_0000_0077);
        udr_finish();
        drain("rstmid_after");
        n_cmp++;
        if (strobe_cnt != s0 + 1) begin
            n_bad++;
            $display("FAIL rstmid_new: strobes=%0d expected 1", strobe_cnt - s0);
        end
    endtask

    initial begin
        n_cmp      = 0;
        n_bad      = 0;
        strobe_cnt = 0;
        exp_act    = '0;
        exp_nact   = '0;
        test_reset();
        test_basic();
        test_no_action();
        test_overflow();
        test_full_push_pop();
        test_coincident();
        test_reset_mid();
        tick(2);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

endmodule
